// File: rtl/stream_pkg.sv
// stream_pkg: shared state type and elaboration helpers for the FINN stream burst blocks
package stream_pkg;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  function automatic int timer_w(input int timeout);
    return timeout > 0 ? clog2(timeout + 1) : 1;
  endfunction
  function automatic bit burst_len_ok(input int len, input int cw);
    return len >= 1 && (cw >= 31 || len < (1 << cw));
  endfunction
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-slot registered AXI-Stream output stage carrying data and last
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             free_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);
  logic valid_q, valid_d, last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  always_comb begin
    valid_d = load_i ? 1'b1 : valid_q && !ready_i;
    data_d  = load_i ? data_i : data_q;
    last_d  = load_i ? last_i : last_q && !ready_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: rtl/stream_burst_drain.sv
// stream_burst_drain: drains fixed-size TLAST-framed bursts from a FIFO stream, flushing partial bursts after an idle timeout
module stream_burst_drain
  import stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COUNT_W   = 13,
  parameter int BURST_LEN = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic [WIDTH-1:0]   in0_V_V_TDATA,
  input  logic               in0_V_V_TVALID,
  output logic               in0_V_V_TREADY,
  output logic [WIDTH-1:0]   out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  output logic               out_V_V_TLAST,
  output logic [15:0]        bursts_done
);
  localparam int TW = timer_w(TIMEOUT);
  localparam logic [COUNT_W-1:0] BLEN = COUNT_W'(BURST_LEN);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  if (!burst_len_ok(BURST_LEN, COUNT_W)) begin : g_bad_burst_len
    $error("stream_burst_drain: BURST_LEN must lie in 1..2**COUNT_W-1");
  end
  if (TIMEOUT < 0) begin : g_bad_timeout
    $error("stream_burst_drain: TIMEOUT must be non-negative");
  end
  state_t state_q, state_d;
  logic [COUNT_W-1:0] beats_q, beats_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] done_q, done_d;
  logic slot_free, accept;
  // reads are gated by reset so the FIFO is never popped while we are being cleared
  assign in0_V_V_TREADY = ap_rst_n && state_q == DRAIN && beats_q != '0 && slot_free;
  assign accept = in0_V_V_TVALID && in0_V_V_TREADY;
  assign bursts_done = done_q;
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    timer_d = timer_q;
    done_d  = done_q;
    if (state_q == IDLE) begin
      if (fifo_count >= BLEN) begin
        beats_d = BLEN;
        timer_d = '0;
        state_d = DRAIN;
      end else if (fifo_count == '0) begin
        timer_d = '0;
      end else if (TIMEOUT != 0 && timer_q == TLIM) begin
        beats_d = fifo_count;
        timer_d = '0;
        state_d = DRAIN;
      end else if (timer_q != '1) begin
        timer_d = timer_q + 1'b1;
      end
    end else if (accept) begin
      beats_d = beats_q - 1'b1;
      done_d  = beats_q == COUNT_W'(1) ? done_q + 16'd1 : done_q;
      state_d = beats_q == COUNT_W'(1) ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      beats_q <= '0;
      timer_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end
  stream_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .load_i (accept),
    .data_i (in0_V_V_TDATA),
    .last_i (beats_q == COUNT_W'(1)),
    .ready_i(out_V_V_TREADY),
    .free_o (slot_free),
    .valid_o(out_V_V_TVALID),
    .data_o (out_V_V_TDATA),
    .last_o (out_V_V_TLAST)
  );
endmodule

// File: tb/tb_stream_burst_drain.sv
// tb_stream_burst_drain: scoreboard bench with a FIFO model feeding stream_burst_drain
module tb_stream_burst_drain;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, oready = 1'b1, push = 1'b0;
  logic [7:0] push_data = '0;
  logic [12:0] count;
  logic [7:0] idata, odata, odata_z;
  logic ivalid, iready, ovalid, olast, iready_z, ovalid_z, olast_z;
  logic [15:0] done, done_z;
  logic [7:0] mem [256];
  int wr = 0, rd = 0, cyc = 0, n_checks = 0, n_errors = 0, done_exp = 0, z_reads = 0, z_valids = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  int beat_cyc[$];
  logic p_v = 1'b0, p_r = 1'b0, p_l = 1'b0;
  logic [7:0] p_d = '0;

  assign count  = 13'(wr - rd);
  assign ivalid = wr != rd;
  assign idata  = mem[8'(rd)];

  always @(posedge clk) begin
    if (ivalid && iready) rd <= rd + 1;
    if (push) begin
      mem[8'(wr)] <= push_data;
      wr <= wr + 1;
    end
  end

  stream_burst_drain #(.WIDTH(8), .COUNT_W(13), .BURST_LEN(4), .TIMEOUT(8)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .fifo_count(count),
    .in0_V_V_TDATA(idata), .in0_V_V_TVALID(ivalid), .in0_V_V_TREADY(iready),
    .out_V_V_TDATA(odata), .out_V_V_TVALID(ovalid), .out_V_V_TREADY(oready),
    .out_V_V_TLAST(olast), .bursts_done(done)
  );

  stream_burst_drain #(.WIDTH(8), .COUNT_W(13), .BURST_LEN(4), .TIMEOUT(0)) dut_z (
    .ap_clk(clk), .ap_rst_n(rst_n), .fifo_count(13'd3),
    .in0_V_V_TDATA(8'hA5), .in0_V_V_TVALID(1'b1), .in0_V_V_TREADY(iready_z),
    .out_V_V_TDATA(odata_z), .out_V_V_TVALID(ovalid_z), .out_V_V_TREADY(1'b1),
    .out_V_V_TLAST(olast_z), .bursts_done(done_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_beat(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    tick(1);
    push = 1'b0;
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    check(tag, 32'(exp_q.size()), 0);
    tick(2);
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (iready_z) z_reads++;
      if (ovalid_z) z_valids++;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("last_wo_valid", 32'(olast && !ovalid), 0);
      if (p_v && !p_r) begin
        check("stall_valid", 32'(ovalid), 1);
        check("stall_data", 32'(odata), 32'(p_d));
        check("stall_last", 32'(olast), 32'(p_l));
      end
      if (ovalid && !oready) check("stall_in_rdy", 32'(iready), 0);
      if (ovalid && oready) begin
        if (exp_q.size() == 0) check("extra_beat", 32'(ovalid), 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(odata), 32'(e[7:0]));
          check("beat_last", 32'(olast), 32'(e[8]));
          beat_cyc.push_back(cyc);
        end
      end
    end
    p_v = ovalid && rst_n;
    p_r = oready;
    p_d = odata;
    p_l = olast;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, s;
    logic [3:0] pat;
    tick(3);
    check("rst_valid", 32'(ovalid), 0);
    check("rst_last", 32'(olast), 0);
    check("rst_data", 32'(odata), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_rdy", 32'(iready), 0);
    rst_n = 1'b1;
    // full burst, first TVALID two edges after count reaches BURST_LEN
    for (int i = 0; i < 4; i++) exp_beat(8'(8'h10 + i), i == 3);
    for (int i = 0; i < 4; i++) push_beat(8'(8'h10 + i));
    check("t1_valid_e0", 32'(ovalid), 0);
    tick(1);
    check("t1_valid_e1", 32'(ovalid), 0);
    tick(1);
    check("t1_valid_e2", 32'(ovalid), 1);
    check("t1_data_e2", 32'(odata), 32'h10);
    done_exp++;
    wait_drain("t1_drain");
    check("t1_done", 32'(done), 32'(done_exp));
    // partial burst flushed after the idle timeout
    for (int i = 0; i < 3; i++) exp_beat(8'(8'h20 + i), i == 2);
    for (int i = 0; i < 3; i++) push_beat(8'(8'h20 + i));
    tick(4);
    check("t2_no_read", 32'(iready), 0);
    check("t2_no_valid", 32'(ovalid), 0);
    done_exp++;
    wait_drain("t2_drain");
    check("t2_done", 32'(done), 32'(done_exp));
    // downstream stalls mid-burst
    for (int i = 0; i < 4; i++) exp_beat(8'(8'h30 + i), i == 3);
    for (int i = 0; i < 4; i++) push_beat(8'(8'h30 + i));
    t = 0;
    while (!ovalid && t < 50) begin
      tick(1);
      t++;
    end
    check("t3_valid", 32'(ovalid), 1);
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      oready = pat[i];
      tick(1);
    end
    oready = 1'b1;
    done_exp++;
    wait_drain("t3_drain");
    check("t3_done", 32'(done), 32'(done_exp));
    // two back-to-back full bursts
    s = beat_cyc.size();
    for (int i = 0; i < 8; i++) exp_beat(8'(8'h40 + i), i == 3 || i == 7);
    for (int i = 0; i < 8; i++) push_beat(8'(8'h40 + i));
    done_exp += 2;
    wait_drain("t4_drain");
    check("t4_done", 32'(done), 32'(done_exp));
    check("t4_beats", 32'(beat_cyc.size() - s), 8);
    if (beat_cyc.size() - s == 8) begin
      check("t4_rate_b1", 32'(beat_cyc[s+3] - beat_cyc[s]), 3);
      check("t4_rate_b2", 32'(beat_cyc[s+7] - beat_cyc[s+4]), 3);
    end
    // reset in the middle of a burst
    exp_beat(8'h50, 1'b0);
    exp_beat(8'h51, 1'b0);
    for (int i = 0; i < 4; i++) push_beat(8'(8'h50 + i));
    t = 0;
    while (!(ovalid && odata == 8'h52) && t < 50) begin
      tick(1);
      t++;
    end
    check("t5_reach", 32'(ovalid && odata == 8'h52), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rdy_rst", 32'(iready), 0);
    tick(1);
    check("t5_valid", 32'(ovalid), 0);
    check("t5_last", 32'(olast), 0);
    check("t5_done", 32'(done), 0);
    check("t5_data", 32'(odata), 0);
    check("t5_count", 32'(count), 1);
    tick(1);
    rst_n = 1'b1;
    done_exp = 1;
    exp_beat(8'h53, 1'b1);
    wait_drain("t5_drain");
    check("t5_done_after", 32'(done), 32'(done_exp));
    // TIMEOUT=0 instance never reads a partial burst
    z_reads = 0;
    z_valids = 0;
    tick(2000);
    check("t6_z_reads", 32'(z_reads), 0);
    check("t6_z_valids", 32'(z_valids), 0);
    check("t6_z_valid", 32'(ovalid_z), 0);
    check("t6_z_done", 32'(done_z), 0);
    check("t6_main_idle", 32'(ovalid), 0);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
